// File: rtl/counter_pkg.sv
// Shared constants for up/down counters: boundary mode and direction encodings,
// plus the elaboration-time parameter legality check.
package counter_pkg;

    localparam int CNT_MODE_WRAP = 0;
    localparam int CNT_MODE_SAT  = 1;

    typedef enum logic {
        CNT_DIR_DOWN = 1'b0,
        CNT_DIR_UP   = 1'b1
    } cnt_dir_e;

    // Widths of 31+ bits can hold any positive int MAX_COUNT.
    function automatic bit cnt_params_ok(input int width, input int max_count, input int saturate);
        bit ok;
        ok = (width >= 1) && (max_count >= 1);
        if (ok && width < 31) begin
            ok = (max_count <= ((1 << width) - 1));
        end
        ok = ok && ((saturate == CNT_MODE_WRAP) || (saturate == CNT_MODE_SAT));
        return ok;
    endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle between a counter and its user. The master drives the
// step/clear/load controls; the slave (the counter) returns count, tc and rollover.
interface counter_updown_mod_if #(
    parameter int WIDTH = 8
) ();

    logic             enable;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             rollover;

    modport master (
        output enable, clear, load, load_value, up,
        input  count, tc, rollover
    );

    modport slave (
        input  enable, clear, load, load_value, up,
        output count, tc, rollover
    );

endinterface

// File: rtl/counter_next_calc.sv
// Combinational next-count arithmetic: step value with wrap/saturate at the bounds,
// boundary detect for the current direction, and load clamp. Zero latency, no flow control.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255,
    parameter int SATURATE  = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] step_o,
    output logic             bound_o,
    output logic [WIDTH-1:0] load_o
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
    localparam bit               SAT   = (SATURATE == CNT_MODE_SAT);

    logic at_max;
    logic at_zero;
    logic dir_up;

    assign at_max  = (count_i == MAX_W);
    assign at_zero = (count_i == '0);
    assign dir_up  = (cnt_dir_e'(up_i) == CNT_DIR_UP);
    assign bound_o = dir_up ? at_max : at_zero;
    assign load_o  = (load_value_i > MAX_W) ? MAX_W : load_value_i;

    always_comb begin
        step_o = count_i;
        if (dir_up) begin
            if (at_max) begin
                step_o = SAT ? MAX_W : '0;
            end else begin
                step_o = count_i + WIDTH'(1);
            end
        end else begin
            if (at_zero) begin
                step_o = SAT ? '0 : MAX_W;
            end else begin
                step_o = count_i - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with clear > load > step priority, wrap or saturate at the bounds.
// count/rollover update one edge after sampling, tc is combinational; always accepts inputs.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255,
    parameter int SATURATE  = CNT_MODE_WRAP
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_updown_mod_if.slave  bus
);

    if (!cnt_params_ok(WIDTH, MAX_COUNT, SATURATE)) begin : g_bad_params
        $error("counter_updown_mod: illegal WIDTH/MAX_COUNT/SATURATE combination");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             rollover_q;
    logic             rollover_d;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;
    logic             bound;

    counter_next_calc #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .SATURATE  (SATURATE)
    ) u_next (
        .count_i      (count_q),
        .up_i         (bus.up),
        .load_value_i (bus.load_value),
        .step_o       (step_val),
        .bound_o      (bound),
        .load_o       (load_val)
    );

    always_comb begin
        count_d    = count_q;
        rollover_d = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = load_val;
        end else if (bus.enable) begin
            count_d    = step_val;
            rollover_d = bound;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            rollover_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
        end
    end

    // tc looks ahead to the next edge and deliberately ignores clear/load.
    assign bus.tc       = bus.enable & bound;
    assign bus.count    = count_q;
    assign bus.rollover = rollover_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Three counter configurations (4-bit mod-10 wrap, 4-bit mod-10 saturate, 8-bit full-range wrap)
// share one stimulus stream; expectations are queued by the driver and checked by a monitor.
module tb_counter_updown_mod;

    typedef struct packed {
        logic [2:0][7:0] cnt;
        logic [2:0]      rol;
        logic [2:0]      tc;
    } exp_t;

    logic clk;
    logic rst_n;

    counter_updown_mod_if #(.WIDTH(4)) if_a ();
    counter_updown_mod_if #(.WIDTH(4)) if_b ();
    counter_updown_mod_if #(.WIDTH(8)) if_c ();

    counter_updown_mod #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut_a (
        .clk(clk), .reset(rst_n), .bus(if_a));
    counter_updown_mod #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) dut_b (
        .clk(clk), .reset(rst_n), .bus(if_b));
    counter_updown_mod #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(0)) dut_c (
        .clk(clk), .reset(rst_n), .bus(if_c));

    logic [7:0] act_cnt [3];
    logic       act_rol [3];
    logic       act_tc  [3];

    assign act_cnt[0] = {4'b0, if_a.count};
    assign act_cnt[1] = {4'b0, if_b.count};
    assign act_cnt[2] = if_c.count;
    assign act_rol[0] = if_a.rollover;
    assign act_rol[1] = if_b.rollover;
    assign act_rol[2] = if_c.rollover;
    assign act_tc[0]  = if_a.tc;
    assign act_tc[1]  = if_b.tc;
    assign act_tc[2]  = if_c.tc;

    int   maxv [3] = '{9, 9, 255};
    bit   satv [3] = '{1'b0, 1'b1, 1'b0};
    int   mc   [3];
    int   mr   [3];
    exp_t sb_q [$];
    int   n_cmp;
    int   n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, predict the response from the counting rules, advance to posedge+2.
    task automatic drive(input bit en, input bit clr, input bit ld, input bit [7:0] lv, input bit u);
        exp_t e;
        int   lvi;
        if_a.enable = en; if_a.clear = clr; if_a.load = ld; if_a.load_value = lv[3:0]; if_a.up = u;
        if_b.enable = en; if_b.clear = clr; if_b.load = ld; if_b.load_value = lv[3:0]; if_b.up = u;
        if_c.enable = en; if_c.clear = clr; if_c.load = ld; if_c.load_value = lv;      if_c.up = u;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            lvi = (i < 2) ? int'(lv[3:0]) : int'(lv);
            e.tc[i] = en && (u ? (mc[i] == maxv[i]) : (mc[i] == 0));
            if (clr) begin
                mc[i] = 0; mr[i] = 0;
            end else if (ld) begin
                mc[i] = (lvi > maxv[i]) ? maxv[i] : lvi; mr[i] = 0;
            end else if (en && u) begin
                if (mc[i] == maxv[i]) begin
                    mr[i] = 1; mc[i] = satv[i] ? maxv[i] : 0;
                end else begin
                    mr[i] = 0; mc[i] = mc[i] + 1;
                end
            end else if (en) begin
                if (mc[i] == 0) begin
                    mr[i] = 1; mc[i] = satv[i] ? 0 : maxv[i];
                end else begin
                    mr[i] = 0; mc[i] = mc[i] - 1;
                end
            end else begin
                mr[i] = 0;
            end
            e.cnt[i] = 8'(mc[i]);
            e.rol[i] = (mr[i] != 0);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_count[%0d]", tag, i), int'(act_cnt[i]), 0);
            check($sformatf("%s_roll[%0d]", tag, i), int'(act_rol[i]), 0);
            check($sformatf("%s_tc[%0d]", tag, i), int'(act_tc[i]), 0);
        end
    endtask

    // Called at posedge+2 once the monitor has finished the previous cycle.
    task automatic async_reset_check();
        if_a.enable = 1'b1; if_a.up = 1'b1; if_a.clear = 1'b0; if_a.load = 1'b0;
        if_b.enable = 1'b1; if_b.up = 1'b1; if_b.clear = 1'b0; if_b.load = 1'b0;
        if_c.enable = 1'b1; if_c.up = 1'b1; if_c.clear = 1'b0; if_c.load = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (2) begin
            @(posedge clk);
            #2;
            check_zero("held_rst");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0; mr[i] = 0;
        end
    endtask

    // Monitor: tc is checked mid-cycle, count/rollover just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int i = 0; i < 3; i++)
                    check($sformatf("tc[%0d]", i), int'(act_tc[i]), int'(e.tc[i]));
                @(posedge clk);
                #1;
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("count[%0d]", i), int'(act_cnt[i]), int'(e.cnt[i]));
                    check($sformatf("rollover[%0d]", i), int'(act_rol[i]), int'(e.rol[i]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit dir;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0; mr[i] = 0;
        end
        if_a.enable = 1'b0; if_a.clear = 1'b0; if_a.load = 1'b0; if_a.load_value = '0; if_a.up = 1'b1;
        if_b.enable = 1'b0; if_b.clear = 1'b0; if_b.load = 1'b0; if_b.load_value = '0; if_b.up = 1'b1;
        if_c.enable = 1'b0; if_c.clear = 1'b0; if_c.load = 1'b0; if_c.load_value = '0; if_c.up = 1'b1;
        rst_n = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        @(posedge clk);
        #2;
        check_zero("reset_edge");
        rst_n = 1'b1;

        repeat (11) drive(1, 0, 0, 8'd0, 1);
        drive(1, 1, 0, 8'd0, 1);
        repeat (4) drive(1, 0, 0, 8'd0, 0);
        repeat (2) drive(1, 0, 0, 8'd0, 1);

        drive(0, 0, 1, 8'd7, 1);
        repeat (5) drive(1, 0, 0, 8'd0, 1);
        drive(1, 0, 0, 8'd0, 0);
        drive(1, 1, 0, 8'd0, 0);
        repeat (3) drive(1, 0, 0, 8'd0, 0);

        drive(0, 0, 1, 8'd5, 1);
        drive(1, 1, 1, 8'd3, 1);
        drive(0, 0, 1, 8'd3, 1);
        drive(0, 0, 1, 8'd12, 1);
        drive(0, 0, 0, 8'd0, 1);

        drive(0, 0, 1, 8'd6, 1);
        async_reset_check();
        repeat (2) drive(1, 0, 0, 8'd0, 1);

        drive(0, 0, 1, 8'd200, 1);
        repeat (20) drive(0, 0, 0, 8'd0, 1);
        repeat (57) drive(1, 0, 0, 8'd0, 1);

        dir = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) dir = ~dir;
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 9) == 0), 8'($urandom), dir);
            if (n == 300) async_reset_check();
        end

        drive(0, 0, 0, 8'd0, 1);
        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
